// File: rtl/updown_counter_sequencer.sv
// updown_counter_sequencer: issues a commanded number of enable steps to an external up/down counter, bouncing or wrapping at the limits
module updown_counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              cmd_bounce,
  input  logic              hold,
  input  logic              abort,
  input  logic [WIDTH-1:0]  cnt_count,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic              busy,
  output logic              done_valid,
  output logic              done_aborted,
  output logic [7:0]        done_wraps
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic              dir;
  logic              bounce;
  logic [STEP_W-1:0] remaining;
  logic [7:0]        wraps;
  logic              aborted;
  logic              at_limit;
  logic              eff_dir;
  logic              issue;
  assign at_limit     = dir ? (cnt_count == '1) : (cnt_count == '0);
  assign eff_dir      = (bounce && at_limit) ? ~dir : dir;
  assign issue        = (state == RUN) && !hold && !abort;
  assign cmd_ready    = state == IDLE;
  assign cnt_enable   = issue;
  assign cnt_up_down  = (state == RUN) ? eff_dir : dir;
  assign busy         = state == RUN;
  assign done_valid   = state == DONE;
  assign done_aborted = aborted;
  assign done_wraps   = wraps;
  // command acceptance, step issue with bounce/wrap tracking, and completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dir       <= 1'b1;
      bounce    <= 1'b0;
      remaining <= '0;
      wraps     <= '0;
      aborted   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          dir       <= cmd_dir;
          bounce    <= cmd_bounce;
          remaining <= cmd_steps;
          wraps     <= '0;
          aborted   <= 1'b0;
          state     <= (cmd_steps == '0) ? DONE : RUN;
        end
        RUN: if (abort) begin
          aborted <= 1'b1;
          state   <= DONE;
        end else if (!hold) begin
          remaining <= remaining - 1'b1;
          dir       <= eff_dir;
          if (!bounce && at_limit && wraps != 8'hff) wraps <= wraps + 8'd1;
          if (remaining == STEP_W'(1)) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_updown_counter_sequencer.sv
// tb_updown_counter_sequencer: directed and randomized commands checked against a step-level reference model
module tb_updown_counter_sequencer;
  logic       clk = 1'b0;
  logic       rst, cmd_valid, cmd_ready, cmd_dir, cmd_bounce, hold, abort;
  logic [7:0] cmd_steps;
  logic [3:0] cnt_count = 4'd0;
  logic [3:0] ld_val;
  logic       ld;
  logic       cnt_enable, cnt_up_down, busy, done_valid, done_aborted;
  logic [7:0] done_wraps;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  updown_counter_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_bounce(cmd_bounce),
    .hold(hold), .abort(abort), .cnt_count(cnt_count),
    .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down), .busy(busy),
    .done_valid(done_valid), .done_aborted(done_aborted), .done_wraps(done_wraps)
  );

  // external counter driven by the sequencer, preloadable by the bench
  always @(posedge clk) begin
    if (ld) cnt_count <= ld_val;
    else if (cnt_enable) cnt_count <= cnt_up_down ? cnt_count + 4'd1 : cnt_count - 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // hold_pct < 0 selects a fixed hold window on RUN cycles 2..4
  task automatic run_cmd(input logic d, input int steps, input logic b, input int start,
                         input int hold_pct, input int abort_after);
    logic [3:0] c;
    logic       dd, e, lim, exp_ab;
    int         w, n, issued, cyc;
    logic       dirs[$];
    c = start[3:0];
    dd = d;
    w = 0;
    exp_ab = (abort_after >= 0 && abort_after < steps);
    n = exp_ab ? abort_after : steps;
    for (int i = 0; i < n; i++) begin
      lim = dd ? (c == 4'hf) : (c == 4'h0);
      e = (b && lim) ? !dd : dd;
      if (!b && lim && w < 255) w++;
      dirs.push_back(e);
      c = e ? c + 4'd1 : c - 4'd1;
      dd = e;
    end
    @(negedge clk);
    ld = 1'b1;
    ld_val = start[3:0];
    @(negedge clk);
    ld = 1'b0;
    chk("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir = d;
    cmd_steps = steps[7:0];
    cmd_bounce = b;
    @(negedge clk);
    cmd_valid = 1'b0;
    issued = 0;
    cyc = 0;
    while (!done_valid && cyc < steps * 10 + 20) begin
      abort = (issued == abort_after);
      hold = (hold_pct < 0) ? (cyc >= 2 && cyc <= 4) : ($urandom_range(99) < hold_pct);
      #1;
      chk("busy_run", busy, 1);
      chk("enable", cnt_enable, !hold && !abort);
      if (cnt_enable) begin
        chk("updown", cnt_up_down, issued < n ? dirs[issued] : 1'bx);
        issued++;
      end
      @(negedge clk);
      abort = 1'b0;
      hold = 1'b0;
      cyc++;
    end
    abort = 1'b1;
    hold = 1'b1;
    #1;
    chk("done_valid", done_valid, 1);
    chk("done_enable", cnt_enable, 0);
    chk("done_ready", cmd_ready, 0);
    chk("issued", issued, n);
    chk("wraps", done_wraps, w);
    chk("aborted", done_aborted, exp_ab);
    chk("final_count", cnt_count, c);
    if (hold_pct < 0) chk("run_cycles", cyc, steps + 3);
    @(negedge clk);
    #1;
    chk("idle_ready", cmd_ready, 1);
    chk("idle_done", done_valid, 0);
    chk("idle_busy", busy, 0);
    chk("held_wraps", done_wraps, w);
    chk("held_aborted", done_aborted, exp_ab);
    abort = 1'b0;
    hold = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_en"}, cnt_enable, 0);
    chk({tag, "_ud"}, cnt_up_down, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dv"}, done_valid, 0);
    chk({tag, "_ab"}, done_aborted, 0);
    chk({tag, "_wr"}, done_wraps, 0);
  endtask

  initial begin
    int k;
    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = 8'd0; cmd_bounce = 1'b0;
    hold = 1'b0; abort = 1'b0; ld = 1'b0; ld_val = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    run_cmd(1'b1, 5, 1'b0, 0, 0, -1);
    run_cmd(1'b1, 6, 1'b1, 13, 0, -1);
    chk("bounce_final", cnt_count, 11);
    run_cmd(1'b1, 4, 1'b0, 3, -1, -1);
    run_cmd(1'b0, 10, 1'b0, 5, 0, 3);
    run_cmd(1'b1, 0, 1'b0, 7, 0, -1);
    run_cmd(1'b1, 20, 1'b0, 0, 0, -1);
    chk("wrap_one", done_wraps, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("rst_idle");
    rst = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = 8'd10; cmd_bounce = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_busy", busy, 1);
    chk("mid_ud", cnt_up_down, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("rst_run");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done_valid) k++;
    end
    chk("no_done_after_rst", k, 0);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 8'd2; cmd_bounce = 1'b0;
    @(negedge clk);
    #1;
    chk("hv_run", busy, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("hv_done", done_valid, 1);
    chk("hv_done_ready", cmd_ready, 0);
    @(negedge clk);
    #1;
    chk("hv_idle_ready", cmd_ready, 1);
    chk("hv_idle_busy", busy, 0);
    @(negedge clk);
    #1;
    chk("hv_reaccept", busy, 1);
    cmd_valid = 1'b0;
    k = 0;
    while (!done_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("hv_second_done", done_valid, 1);
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      run_cmd(1'($urandom_range(1)), int'($urandom_range(40)), 1'($urandom_range(1)),
              int'($urandom_range(15)), 30,
              ($urandom_range(3) == 0) ? int'($urandom_range(20)) : -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
